// File: rtl/cdc_hs_src.sv
// Source side of a two-phase (toggle) request/acknowledge clock-domain crossing.
// Holds one word on data_hold, flips req_tgl, and waits for the synchronized ack toggle.
module cdc_hs_src #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_LEVELS = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk_s,
  input  logic                  rstn_s,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  req_tgl,
  output logic [DATA_WIDTH-1:0] data_hold,
  input  logic                  ack_tgl,
  output logic                  busy,
  output logic                  err_ack,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SYNC_LEVELS-1:0]  r_ack_sync;
  logic                    r_ack_q;
  logic                    w_ack_sync;
  logic                    w_ack_evt;
  logic                    w_accept;
  logic                    w_done;
  logic                    w_spurious;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_req;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_err;
  logic [CNT_WIDTH-1:0]    r_cnt;

  assign w_ack_sync = r_ack_sync[SYNC_LEVELS-1];
  assign w_ack_evt  = w_ack_sync ^ r_ack_q;

  // ack toggle synchronizer chain plus the edge-detect delay flop
  always_ff @(posedge clk_s) begin
    if (!rstn_s) begin
      r_ack_sync <= '0;
      r_ack_q    <= 1'b0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_LEVELS-2:0], ack_tgl};
      r_ack_q    <= w_ack_sync;
    end
  end

  // handshake state register; ready/busy are registered copies of the next state
  always_ff @(posedge clk_s) begin
    if (!rstn_s) begin
      r_state <= ST_RST;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_busy  <= (w_state_nxt == ST_WAIT);
    end
  end

  // next-state and event decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_spurious  = 1'b0;
    case (r_state)
      ST_RST: begin
        w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        // an ack here has no matching request; flag it and keep serving
        if (w_ack_evt) begin
          w_spurious = 1'b1;
        end else begin
          w_spurious = 1'b0;
        end
        if (s_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (w_ack_evt) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_RST;
      end
    endcase
  end

  // launch data/request, completion counter and sticky spurious-ack flag
  always_ff @(posedge clk_s) begin
    if (!rstn_s) begin
      r_req  <= 1'b0;
      r_data <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_req  <= ~r_req;
        r_data <= s_data;
      end
      if (w_done) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (w_spurious) begin
        r_err <= 1'b1;
      end
    end
  end

  assign s_ready   = r_ready;
  assign busy      = r_busy;
  assign req_tgl   = r_req;
  assign data_hold = r_data;
  assign err_ack   = r_err;
  assign xfer_cnt  = r_cnt;

endmodule
